// File: rtl/user_sequence_checker.sv
// -----------------------------------------------------------------------------
// user_sequence_checker
//
// Player-side half of the memory game. The game-control FSM starts a round with
// E; this block then waits for the player's button presses one at a time, reads
// the expected button from the sequence ROM at address SEQUSER and compares the
// two. A fully correct round raises tc; the first wrong press raises err. Both
// flags hold until the next start or a reset.
//
// Optional feature: define USER_TIMEOUT_EN to add a per-press timeout. When it
// is enabled, a wait of P_TIMEOUT cycles in WAIT_KEY with no press ends the
// round with err=1 and timeout=1.
//
// Ports
//   clk      in   1       clock, everything on posedge
//   R        in   1       synchronous active-high reset, overrides all inputs
//   E        in   1       start/restart request (honoured in IDLE/DONE/FAIL)
//   data     in   p_data  round limit: last valid ROM address of this round
//   KEY      in   p_key   player buttons, active-high, already synchronised
//   rom_q    in   p_key   ROM word at SEQUSER, 1-cycle read latency
//   SEQUSER  out  p_data  ROM address of the press currently expected
//   match    out  1       1-cycle pulse per correct press
//   tc       out  1       round complete (held)
//   err      out  1       wrong press or timeout (held)
//   busy     out  1       high while a round is in progress
//   timeout  out  1       only with USER_TIMEOUT_EN: round ended by timeout
// -----------------------------------------------------------------------------
module user_sequence_checker #(
  parameter int p_data    = 4,
  parameter int p_key     = 4,
  parameter int P_TIMEOUT = 500
) (
  input  logic              clk,
  input  logic              R,
  input  logic              E,
  input  logic [p_data-1:0] data,
  input  logic [p_key-1:0]  KEY,
  input  logic [p_key-1:0]  rom_q,
  output logic [p_data-1:0] SEQUSER,
  output logic              match,
  output logic              tc,
  output logic              err,
  output logic              busy
`ifdef USER_TIMEOUT_EN
  ,
  output logic              timeout
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_KEY,
    ST_FETCH,
    ST_CHECK,
    ST_DONE,
    ST_FAIL
  } state_t;

  state_t            state_q, state_d;
  logic [p_data-1:0] round_q, round_d;
  logic [p_data-1:0] seq_q,   seq_d;
  logic [p_key-1:0]  key_q,   key_d;
  logic              key_prev_q, key_prev_d;
  logic              match_q, match_d;
  logic              tc_q,    tc_d;
  logic              err_q,   err_d;
  logic              busy_q,  busy_d;

  logic              any_key;
  logic              press;
  logic              key_onehot;
  logic              key_ok;

`ifdef USER_TIMEOUT_EN
  localparam int CW = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(P_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
`endif

  // A press is the rising edge of "any button". key_prev tracks |KEY in every
  // state, so a button already held when the round starts must be released
  // before it can count.
  assign any_key = |KEY;
  assign press   = any_key & ~key_prev_q;

  // Exactly one button captured: non-zero and clearing the lowest set bit
  // leaves nothing behind.
  assign key_onehot = (key_q != '0) && ((key_q & (key_q - 1'b1)) == '0);
  assign key_ok     = key_onehot && (key_q == rom_q);

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic. Every output is computed here as a "_d"
  // value and registered below, so no input reaches an output combinationally.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    seq_d      = seq_q;
    key_d      = key_q;
    key_prev_d = any_key;
    match_d    = 1'b0;
    tc_d       = tc_q;
    err_d      = err_q;
`ifdef USER_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = timeout_q;
`endif

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        // Presses here are discarded; only E does anything.
        if (E) begin
          state_d = ST_WAIT_KEY;
          round_d = data;
          seq_d   = '0;
          tc_d    = 1'b0;
          err_d   = 1'b0;
`ifdef USER_TIMEOUT_EN
          cnt_d     = '0;
          timeout_d = 1'b0;
`endif
        end
      end

      ST_WAIT_KEY: begin
        if (press) begin
          key_d   = KEY;
          state_d = ST_FETCH;
`ifdef USER_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          // A press in this same cycle took the branch above instead.
          err_d     = 1'b1;
          timeout_d = 1'b1;
          state_d   = ST_FAIL;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end

      ST_FETCH: begin
        // SEQUSER has been stable since the press; the ROM presents its word
        // during CHECK.
        state_d = ST_CHECK;
      end

      ST_CHECK: begin
        if (!key_ok) begin
          err_d   = 1'b1;
          state_d = ST_FAIL;
        end else begin
          match_d = 1'b1;
          if (seq_q == round_q) begin
            tc_d    = 1'b1;
            state_d = ST_DONE;
          end else begin
            seq_d   = seq_q + 1'b1;
            state_d = ST_WAIT_KEY;
`ifdef USER_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_WAIT_KEY) || (state_d == ST_FETCH) ||
             (state_d == ST_CHECK);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (R) begin
      state_q    <= ST_IDLE;
      round_q    <= '0;
      seq_q      <= '0;
      key_q      <= '0;
      key_prev_q <= 1'b0;
      match_q    <= 1'b0;
      tc_q       <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef USER_TIMEOUT_EN
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      seq_q      <= seq_d;
      key_q      <= key_d;
      key_prev_q <= key_prev_d;
      match_q    <= match_d;
      tc_q       <= tc_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
`ifdef USER_TIMEOUT_EN
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign SEQUSER = seq_q;
  assign match   = match_q;
  assign tc      = tc_q;
  assign err     = err_q;
  assign busy    = busy_q;
`ifdef USER_TIMEOUT_EN
  assign timeout = timeout_q;
`endif

endmodule
